sign_ext: RTL and testbench



---
 rtl/sign_ext.sv | 79 +++++++
 tb/tb_sign_ext.sv | 106 ++++++++++
 2 files changed

// File: rtl/sign_ext.sv
// LEGv8 immediate sign-extension: decodes D/CB/B formats from the opcode and
// sign-extends the immediate to 64 bits, with a one-cycle registered copy.
module sign_ext (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  output logic [63:0] y,
  output logic [1:0]  fmt,
  output logic [63:0] y_r,
  output logic [1:0]  fmt_r
);

  typedef enum logic [1:0] {
    FMT_NONE = 2'b00,
    FMT_D    = 2'b01,
    FMT_CB   = 2'b10,
    FMT_B    = 2'b11
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [63:0] y;
  } imm_rsp_t;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;

  imm_rsp_t rsp;
  logic     is_d, is_cb, is_b;

  assign is_d  = (a[31:21] == OP_LDUR) || (a[31:21] == OP_STUR);
  assign is_cb = (a[31:24] == OP_CBZ)  || (a[31:24] == OP_CBNZ);
  assign is_b  = (a[31:26] == OP_B)    || (a[31:26] == OP_BL);

  // Opcode sets are disjoint, so the order of these tests carries no priority.
  always_comb begin
    rsp.fmt = FMT_NONE;
    rsp.y   = 64'h0;
    if (is_d) begin
      rsp.fmt = FMT_D;
      rsp.y   = {{55{a[20]}}, a[20:12]};
    end else if (is_cb) begin
      rsp.fmt = FMT_CB;
      rsp.y   = {{45{a[23]}}, a[23:5]};
    end else if (is_b) begin
      rsp.fmt = FMT_B;
      rsp.y   = {{38{a[25]}}, a[25:0]};
    end
  end

  assign y   = rsp.y;
  assign fmt = rsp.fmt;

  logic [63:0] y_d, y_q;
  logic [1:0]  fmt_d, fmt_q;

  always_comb begin
    y_d   = rsp.y;
    fmt_d = rsp.fmt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q   <= 64'h0;
      fmt_q <= 2'b00;
    end else begin
      y_q   <= y_d;
      fmt_q <= fmt_d;
    end
  end

  assign y_r   = y_q;
  assign fmt_r = fmt_q;

endmodule

// File: tb/tb_sign_ext.sv
// Directed bench for sign_ext: decode vectors, register pipeline, async reset.
module tb_sign_ext;
  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [63:0] y, y_r;
  logic [1:0]  fmt, fmt_r;

  int checks   = 0;
  int failures = 0;

  sign_ext dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .y    (y),
    .fmt  (fmt),
    .y_r  (y_r),
    .fmt_r(fmt_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb(input logic [31:0] ai, input logic [63:0] ey, input logic [1:0] ef, input string tag);
    a = ai;
    #1;
    check({tag, "_y"}, y, ey);
    check({tag, "_fmt"}, {62'h0, fmt}, {62'h0, ef});
  endtask

  initial begin
    reset = 1'b0;
    a     = 32'h0;
    @(negedge clk);
    check("rst_y_r", y_r, 64'h0);
    check("rst_fmt_r", {62'h0, fmt_r}, 64'h0);

    comb(32'hF84A9F02, 64'h00000000000000A9, 2'b01, "ldur_pos");
    comb(32'hF85A9F01, 64'hFFFFFFFFFFFFFFA9, 2'b01, "ldur_neg");
    comb(32'hF80A9F01, 64'h00000000000000A9, 2'b01, "stur_pos");
    comb(32'hF81A9F01, 64'hFFFFFFFFFFFFFFA9, 2'b01, "stur_neg");
    comb(32'hB40A9F01, 64'h00000000000054F8, 2'b10, "cbz_pos");
    comb(32'hB48A9F01, 64'hFFFFFFFFFFFC54F8, 2'b10, "cbz_neg");
    comb(32'hB50A9F01, 64'h00000000000054F8, 2'b10, "cbnz_pos");
    comb(32'h14000010, 64'h0000000000000010, 2'b11, "b_pos");
    comb(32'h97FFFFFF, 64'hFFFFFFFFFFFFFFFF, 2'b11, "bl_neg");
    comb(32'h550A9F01, 64'h0, 2'b00, "unk_a");
    comb(32'h551A9F01, 64'h0, 2'b00, "unk_b");
    comb(32'h00000000, 64'h0, 2'b00, "unk_zero");
    // register fields differ from ldur_pos; result must not change
    comb(32'hF84A93FF, 64'h00000000000000A9, 2'b01, "ldur_regs");

    // reset held through edges keeps registers clear
    @(negedge clk);
    check("rst_hold_y_r", y_r, 64'h0);

    reset = 1'b1;
    a = 32'hF85A9F01;
    @(negedge clk);
    check("pipe0_y_r", y_r, 64'hFFFFFFFFFFFFFFA9);
    check("pipe0_fmt_r", {62'h0, fmt_r}, 64'h1);
    a = 32'hB40A9F01;
    #1;
    check("pipe1_hold_y_r", y_r, 64'hFFFFFFFFFFFFFFA9);
    @(negedge clk);
    check("pipe1_y_r", y_r, 64'h00000000000054F8);
    check("pipe1_fmt_r", {62'h0, fmt_r}, 64'h2);

    // async reset between edges
    #2;
    reset = 1'b0;
    #1;
    check("async_y_r", y_r, 64'h0);
    check("async_fmt_r", {62'h0, fmt_r}, 64'h0);
    check("async_y_live", y, 64'h00000000000054F8);
    a = 32'h97FFFFFF;
    #1;
    check("async_y_follow", y, 64'hFFFFFFFFFFFFFFFF);
    check("async_y_r_hold", y_r, 64'h0);
    @(negedge clk);
    check("async_y_r_edge", y_r, 64'h0);

    a = 32'h14000010;
    reset = 1'b1;
    @(negedge clk);
    check("release_y_r", y_r, 64'h0000000000000010);
    check("release_fmt_r", {62'h0, fmt_r}, 64'h3);

    a = 32'h550A9F01;
    @(negedge clk);
    check("unk_y_r", y_r, 64'h0);
    check("unk_fmt_r", {62'h0, fmt_r}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
